// File: rtl/uart_pkg.sv
// Shared definitions for the packet UART transmitter.
// Header layout: {type[1:0], mem_type, addr[8:0]}.
package uart_pkg;

   localparam logic [1:0] HDR_WRITE = 2'b11;
   localparam logic [1:0] HDR_READ  = 2'b01;

   localparam int HDR_ADDR_W = 9;
   localparam int HDR_W      = 12;

   localparam int DEF_DATA_BITS    = 12;
   localparam int DEF_CLKS_PER_BIT = 868;

   typedef struct packed {
      logic [1:0]            kind;
      logic                  mem;
      logic [HDR_ADDR_W-1:0] addr;
   } hdr_t;

   function automatic hdr_t make_hdr(
      input logic                  rw,
      input logic                  mem,
      input logic [HDR_ADDR_W-1:0] addr
   );
      hdr_t h;
      h.kind = rw ? HDR_WRITE : HDR_READ;
      h.mem  = mem;
      h.addr = addr;
      return h;
   endfunction

endpackage

// File: rtl/uart_bits_tx.sv
// Single UART frame serializer: start bit, DATA_BITS LSB-first, stop bit.
// A load on the stop-bit's last cycle chains frames back-to-back.
module uart_bits_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_load,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_frame_done
);

   localparam int BW = $clog2(CLKS_PER_BIT + 1);
   localparam int NW = $clog2(DATA_BITS + 2);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS + 1);

   logic [BW-1:0]      r_baud;
   logic [NW-1:0]      r_bit;
   logic [DATA_BITS:0] r_shift;
   logic               r_tx;
   logic               r_busy;
   logic               w_bit_end;

   assign w_bit_end    = r_busy && (r_baud == BAUD_LAST);
   assign o_frame_done = w_bit_end && (r_bit == BIT_LAST);
   assign o_tx         = r_tx;
   assign o_busy       = r_busy;

   // r_shift carries the stop bit above the payload so it falls out last
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else if (i_load) begin
         r_tx    <= 1'b0;
         r_busy  <= 1'b1;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= {1'b1, i_data};
      end else if (w_bit_end) begin
         r_baud <= '0;
         if (r_bit == BIT_LAST) begin
            r_busy <= 1'b0;
            r_tx   <= 1'b1;
         end else begin
            r_bit   <= r_bit + 1'b1;
            r_tx    <= r_shift[0];
            r_shift <= {1'b1, r_shift[DATA_BITS:1]};
         end
      end else if (r_busy) begin
         r_baud <= r_baud + 1'b1;
      end
   end

endmodule

// File: rtl/uart_bytes_tx.sv
// Packet UART transmitter: header frame, then BYTE_COUNT data frames
// (MSB byte first) for writes. Inputs are captured on the accepting edge.
module uart_bytes_tx
   import uart_pkg::*;
#(
   parameter int BYTE_COUNT   = 4,
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic                    i_rw_flag,
   input  logic                    i_target_mem_type,
   input  logic [HDR_ADDR_W-1:0]   i_target_addr,
   input  logic [8*BYTE_COUNT-1:0] i_data_in,
   output logic                    o_tx,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HEADER = 2'd1;
   localparam logic [1:0] S_DATA   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int CW = $clog2(BYTE_COUNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BYTE_COUNT - 1);

   logic [1:0]              r_state;
   logic [CW-1:0]           r_cnt;
   logic                    r_rw;
   logic [8*BYTE_COUNT-1:0] r_data;
   logic                    r_busy;
   logic                    r_done;

   logic                 w_load;
   logic [DATA_BITS-1:0] w_frame;
   logic [HDR_W-1:0]     w_hdr;
   logic                 w_frame_done;
   logic                 w_line_busy;

   assign w_hdr  = make_hdr(i_rw_flag, i_target_mem_type, i_target_addr);
   assign o_busy = r_busy;
   assign o_done = r_done;

   // r_data shifts left per data frame, so the next byte is always on top
   always_comb begin
      w_load  = 1'b0;
      w_frame = DATA_BITS'(w_hdr);
      case (r_state)
         S_IDLE: w_load = i_start && !w_line_busy;
         S_HEADER: begin
            w_load  = w_frame_done && r_rw;
            w_frame = DATA_BITS'(r_data[8*BYTE_COUNT-1 -: 8]);
         end
         S_DATA: begin
            w_load  = w_frame_done && (r_cnt != CNT_LAST);
            w_frame = DATA_BITS'(r_data[8*BYTE_COUNT-1 -: 8]);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rw    <= 1'b0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_load) begin
                  r_state <= S_HEADER;
                  r_busy  <= 1'b1;
                  r_rw    <= i_rw_flag;
                  r_data  <= i_data_in;
                  r_cnt   <= '0;
               end
            end
            S_HEADER: begin
               if (w_frame_done) begin
                  if (r_rw) begin
                     r_state <= S_DATA;
                     r_data  <= r_data << 8;
                     r_cnt   <= '0;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (w_frame_done) begin
                  if (r_cnt == CNT_LAST) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt  <= r_cnt + 1'b1;
                     r_data <= r_data << 8;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   uart_bits_tx #(
      .DATA_BITS    (DATA_BITS),
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bits (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_load       (w_load),
      .i_data       (w_frame),
      .o_tx         (o_tx),
      .o_busy       (w_line_busy),
      .o_frame_done (w_frame_done)
   );

endmodule

// File: tb/tb_uart_bytes_tx.sv
// Randomized bench for uart_bytes_tx against a frame-list line model.
// Each packet is compared cycle by cycle and decoded frame by frame.
module tb_uart_bytes_tx;

   localparam int BC  = 4;
   localparam int DB  = 12;
   localparam int CPB = 4;
   localparam int FRM = (DB + 2) * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        rw;
   logic        mem;
   logic [8:0]  addr;
   logic [31:0] din;
   logic        tx;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_bytes_tx #(
      .BYTE_COUNT   (BC),
      .DATA_BITS    (DB),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_start           (start),
      .i_rw_flag         (rw),
      .i_target_mem_type (mem),
      .i_target_addr     (addr),
      .i_data_in         (din),
      .o_tx              (tx),
      .o_busy            (busy),
      .o_done            (done)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Frame k of a packet: 0 is the header, 1..BC the data bytes MSB first
   function automatic logic [11:0] frame_of(input logic r, input logic m,
         input logic [8:0] a, input logic [31:0] d, input int k);
      logic [31:0] sh;
      if (k == 0) return {(r ? 2'b11 : 2'b01), m, a};
      sh = d >> (8 * (BC - k));
      return {4'h0, sh[7:0]};
   endfunction

   function automatic logic exp_tx(input logic r, input logic m,
         input logic [8:0] a, input logic [31:0] d, input int t,
         input int nf);
      int f;
      int b;
      logic [11:0] fr;
      if (t >= nf * FRM) return 1'b1;
      f = t / FRM;
      b = (t % FRM) / CPB;
      if (b == 0) return 1'b0;
      if (b == DB + 1) return 1'b1;
      fr = frame_of(r, m, a, d, f);
      return fr[b-1];
   endfunction

   // mode 0: plain, 1: stray starts + input changes, 2: reset at E0+30
   task automatic run_packet(input logic p_rw, input logic p_mem,
         input logic [8:0] p_addr, input logic [31:0] p_data,
         input int mode);
      int nf;
      int last;
      int lim;
      int bad_tx;
      int bad_busy;
      int n_done;
      int done_at;
      logic wave[$];
      logic [11:0] fr;
      nf       = p_rw ? 1 + BC : 1;
      last     = nf * FRM;
      lim      = (mode == 2) ? 40 : last + 3;
      bad_tx   = 0;
      bad_busy = 0;
      n_done   = 0;
      done_at  = -1;
      @(negedge clk);
      rw    = p_rw;
      mem   = p_mem;
      addr  = p_addr;
      din   = p_data;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int t = 0; t < lim; t++) begin
         logic etx;
         logic ebusy;
         logic edone;
         if (t > 0) begin
            @(posedge clk);
            #1;
         end
         if (mode == 2 && t > 30) begin
            etx   = 1'b1;
            ebusy = 1'b0;
            edone = 1'b0;
         end else begin
            etx   = exp_tx(p_rw, p_mem, p_addr, p_data, t, nf);
            ebusy = (t <= last);
            edone = (t == last);
         end
         wave.push_back(tx);
         if (tx !== etx) bad_tx++;
         if (busy !== ebusy) bad_busy++;
         if (done === 1'b1) begin
            n_done++;
            done_at = t;
         end
         if (done !== edone && done !== 1'b1) bad_busy++;
         start = 1'b0;
         reset = (mode == 2 && t == 30);
         if (mode == 1 && (t == 10 || t == last)) begin
            start = 1'b1;
            rw    = ~p_rw;
            mem   = ~p_mem;
            addr  = ~p_addr;
            din   = ~p_data;
         end
      end
      reset = 1'b0;
      start = 1'b0;
      check("tx_wave", bad_tx, 0);
      check("busy_wave", bad_busy, 0);
      if (mode == 2) begin
         check("rst_no_done", n_done, 0);
      end else begin
         check("done_cnt", n_done, 1);
         check("done_at", done_at, last);
         for (int f = 0; f < nf; f++) begin
            fr = '0;
            for (int b = 0; b < DB; b++)
               fr[b] = wave[f*FRM + (b+1)*CPB + CPB/2];
            check($sformatf("frame%0d", f), {20'h0, fr},
                  {20'h0, frame_of(p_rw, p_mem, p_addr, p_data, f)});
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      rw    = 1'b0;
      mem   = 1'b0;
      addr  = '0;
      din   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      run_packet(1'b1, 1'b1, 9'h05A, 32'hDEADBEEF, 0);
      run_packet(1'b0, 1'b0, 9'h1FF, 32'hFFFFFFFF, 0);
      run_packet(1'b1, 1'b0, 9'h0C3, 32'h12345678, 1);
      run_packet(1'b0, 1'b1, 9'h101, 32'h0BADF00D, 1);
      run_packet(1'b1, 1'b1, 9'h0AA, 32'hCAFEF00D, 2);
      run_packet(1'b1, 1'b1, 9'h0AA, 32'hCAFEF00D, 0);
      run_packet(1'b1, 1'b0, 9'h000, 32'h00000000, 0);

      for (int i = 0; i < 50; i++)
         run_packet(1'b1, 1'($urandom_range(0, 1)), 9'($urandom),
                    $urandom, int'($urandom_range(0, 1)));
      for (int i = 0; i < 10; i++)
         run_packet(1'b0, 1'($urandom_range(0, 1)), 9'($urandom),
                    $urandom, int'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
